// File: rtl/cube_line_rotator.sv
// ----------------------------------------------------------------------------
// cube_line_rotator
//
// Rotation engine for the cube wireframe. For one edge (single mode) or for
// all twelve edges (sweep mode) it fetches both endpoint vertices from a
// built-in cube table. It rotates them about X, then Y, then Z using cos/sin
// coefficients latched at start, adds the screen offsets and saturates the
// result. Each endpoint pair is presented to the line drawer on a
// valid/ready handshake.
//
// Handshake: out_valid_o is raised once a pair is ready. While out_valid_o=1
// and out_ready_i=0 the pair, out_line_o and frame_done_o stay stable. A pair
// is transferred on a rising clk edge where out_valid_o & out_ready_i.
//
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   start_i                        request, sampled only while idle
//   sweep_i                        with start_i: 1 = edges 0..11, 0 = line_num_i only
//   line_num_i[3:0]                edge index for single mode (0..11 valid)
//   cos_/sin_{x,y,z}_i             signed coefficients, 1.0 = 2^FRAC_BITS
//   out_ready_i                    consumer ready
//   busy_o                         high whenever the engine is not idle
//   out_valid_o                    endpoint pair valid
//   out_line_o[3:0]                edge index of the presented pair
//   x0_o..z1_o                     signed saturated endpoints
//   frame_done_o                   high with the edge-11 pair of a sweep
//   bad_line_o                     1-cycle pulse: single start with line_num_i > 11 rejected
//   state_o[2:0]                   current FSM state (debug)
// ----------------------------------------------------------------------------
module cube_line_rotator #(
   parameter int COORD_W   = 13,
   parameter int COEF_W    = 8,
   parameter int FRAC_BITS = 6,
   parameter int HALF      = 10,
   parameter int X_OFF     = 320,
   parameter int Y_OFF     = 240,
   parameter int Z_OFF     = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start_i,
   input  logic                      sweep_i,
   input  logic [3:0]                line_num_i,
   input  logic signed [COEF_W-1:0]  cos_x_i,
   input  logic signed [COEF_W-1:0]  sin_x_i,
   input  logic signed [COEF_W-1:0]  cos_y_i,
   input  logic signed [COEF_W-1:0]  sin_y_i,
   input  logic signed [COEF_W-1:0]  cos_z_i,
   input  logic signed [COEF_W-1:0]  sin_z_i,
   input  logic                      out_ready_i,
   output logic                      busy_o,
   output logic                      out_valid_o,
   output logic [3:0]                out_line_o,
   output logic signed [COORD_W-1:0] x0_o,
   output logic signed [COORD_W-1:0] y0_o,
   output logic signed [COORD_W-1:0] z0_o,
   output logic signed [COORD_W-1:0] x1_o,
   output logic signed [COORD_W-1:0] y1_o,
   output logic signed [COORD_W-1:0] z1_o,
   output logic                      frame_done_o,
   output logic                      bad_line_o,
   output logic [2:0]                state_o
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_ROTX = 3'd2,
      S_ROTY = 3'd3,
      S_ROTZ = 3'd4,
      S_OUT  = 3'd5
   } state_t;

   localparam int PW      = COORD_W + COEF_W + 1;
   localparam int RND     = 1 << (FRAC_BITS - 1);
   localparam int SAT_MAX = (1 << (COORD_W - 1)) - 1;
   localparam int SAT_MIN = -(1 << (COORD_W - 1));
   localparam logic signed [COORD_W-1:0] VP = COORD_W'(HALF);
   localparam logic signed [COORD_W-1:0] VN = COORD_W'(-HALF);

   // a*ca +/- b*cb, rounded half up and scaled back by the fraction bits.
   function automatic logic signed [COORD_W-1:0] rot_term(
      input logic signed [COORD_W-1:0] a,
      input logic signed [COORD_W-1:0] b,
      input logic signed [COEF_W-1:0]  ca,
      input logic signed [COEF_W-1:0]  cb,
      input logic                      sub
   );
      logic signed [PW-1:0] pa, pb, s;
      pa = PW'(a) * PW'(ca);
      pb = PW'(b) * PW'(cb);
      s  = (sub ? (pa - pb) : (pa + pb)) + PW'(RND);
      s  = s >>> FRAC_BITS;
      return COORD_W'(s);
   endfunction

   function automatic logic signed [COORD_W-1:0] sat_off(
      input logic signed [COORD_W-1:0] v,
      input int                        off
   );
      int s;
      s = int'(v) + off;
      if (s > SAT_MAX)      s = SAT_MAX;
      else if (s < SAT_MIN) s = SAT_MIN;
      return COORD_W'(s);
   endfunction

   // Vertex numbering A..H = 0..7. Bit 2 selects the +z face; bits 1:0 walk
   // the face as (+,+) (+,-) (-,-) (-,+) in (x,y).
   function automatic logic signed [COORD_W-1:0] vert_x(input logic [2:0] v);
      return v[1] ? VN : VP;
   endfunction
   function automatic logic signed [COORD_W-1:0] vert_y(input logic [2:0] v);
      return (v[1] ^ v[0]) ? VN : VP;
   endfunction
   function automatic logic signed [COORD_W-1:0] vert_z(input logic [2:0] v);
      return v[2] ? VP : VN;
   endfunction

   // {start vertex, end vertex} of each edge.
   function automatic logic [5:0] edge_verts(input logic [3:0] ln);
      case (ln)
         4'd0:    return {3'd0, 3'd1};
         4'd1:    return {3'd1, 3'd2};
         4'd2:    return {3'd2, 3'd3};
         4'd3:    return {3'd3, 3'd0};
         4'd4:    return {3'd4, 3'd5};
         4'd5:    return {3'd5, 3'd6};
         4'd6:    return {3'd6, 3'd7};
         4'd7:    return {3'd7, 3'd4};
         4'd8:    return {3'd0, 3'd4};
         4'd9:    return {3'd1, 3'd5};
         4'd10:   return {3'd2, 3'd6};
         default: return {3'd3, 3'd7};
      endcase
   endfunction

   state_t                      state_q, state_d;
   logic signed [COEF_W-1:0]    cx_q, sx_q, cy_q, sy_q, cz_q, sz_q;
   logic                        sweep_q;
   logic [3:0]                  idx_q;
   logic signed [COORD_W-1:0]   px_q [2];
   logic signed [COORD_W-1:0]   py_q [2];
   logic signed [COORD_W-1:0]   pz_q [2];
   logic signed [COORD_W-1:0]   x0_q, y0_q, z0_q, x1_q, y1_q, z1_q;
   logic                        out_valid_q, frame_done_q, bad_line_q;
   logic [3:0]                  out_line_q;
   logic                        accept, last_beat;
   logic [5:0]                  ev;

   assign accept    = (state_q == S_IDLE) && start_i && (sweep_i || (line_num_i <= 4'd11));
   assign last_beat = !sweep_q || (idx_q == 4'd11);
   assign ev        = edge_verts(idx_q);

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_LOAD;
         S_LOAD:  state_d = S_ROTX;
         S_ROTX:  state_d = S_ROTY;
         S_ROTY:  state_d = S_ROTZ;
         S_ROTZ:  state_d = S_OUT;
         S_OUT:   if (out_valid_q && out_ready_i) state_d = last_beat ? S_IDLE : S_LOAD;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cx_q         <= '0;
         sx_q         <= '0;
         cy_q         <= '0;
         sy_q         <= '0;
         cz_q         <= '0;
         sz_q         <= '0;
         sweep_q      <= 1'b0;
         idx_q        <= '0;
         for (int e = 0; e < 2; e++) begin
            px_q[e] <= '0;
            py_q[e] <= '0;
            pz_q[e] <= '0;
         end
         x0_q         <= '0;
         y0_q         <= '0;
         z0_q         <= '0;
         x1_q         <= '0;
         y1_q         <= '0;
         z1_q         <= '0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         bad_line_q   <= 1'b0;
         out_line_q   <= '0;
      end else begin
         bad_line_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  cx_q    <= cos_x_i;
                  sx_q    <= sin_x_i;
                  cy_q    <= cos_y_i;
                  sy_q    <= sin_y_i;
                  cz_q    <= cos_z_i;
                  sz_q    <= sin_z_i;
                  sweep_q <= sweep_i;
                  idx_q   <= sweep_i ? 4'd0 : line_num_i;
               end else if (start_i && !sweep_i) begin
                  // Not accepted with sweep low means the index was out of range.
                  bad_line_q <= 1'b1;
               end
            end
            S_LOAD: begin
               px_q[0] <= vert_x(ev[5:3]);
               py_q[0] <= vert_y(ev[5:3]);
               pz_q[0] <= vert_z(ev[5:3]);
               px_q[1] <= vert_x(ev[2:0]);
               py_q[1] <= vert_y(ev[2:0]);
               pz_q[1] <= vert_z(ev[2:0]);
            end
            S_ROTX: begin
               for (int e = 0; e < 2; e++) begin
                  py_q[e] <= rot_term(py_q[e], pz_q[e], cx_q, sx_q, 1'b1);
                  pz_q[e] <= rot_term(pz_q[e], py_q[e], cx_q, sx_q, 1'b0);
               end
            end
            S_ROTY: begin
               for (int e = 0; e < 2; e++) begin
                  px_q[e] <= rot_term(px_q[e], pz_q[e], cy_q, sy_q, 1'b0);
                  pz_q[e] <= rot_term(pz_q[e], px_q[e], cy_q, sy_q, 1'b1);
               end
            end
            S_ROTZ: begin
               for (int e = 0; e < 2; e++) begin
                  px_q[e] <= rot_term(px_q[e], py_q[e], cz_q, sz_q, 1'b1);
                  py_q[e] <= rot_term(py_q[e], px_q[e], cz_q, sz_q, 1'b0);
               end
            end
            S_OUT: begin
               // First OUT cycle registers the offset/saturated pair; the
               // pair is then held until the consumer takes it.
               if (!out_valid_q) begin
                  x0_q         <= sat_off(px_q[0], X_OFF);
                  y0_q         <= sat_off(py_q[0], Y_OFF);
                  z0_q         <= sat_off(pz_q[0], Z_OFF);
                  x1_q         <= sat_off(px_q[1], X_OFF);
                  y1_q         <= sat_off(py_q[1], Y_OFF);
                  z1_q         <= sat_off(pz_q[1], Z_OFF);
                  out_line_q   <= idx_q;
                  frame_done_q <= sweep_q && (idx_q == 4'd11);
                  out_valid_q  <= 1'b1;
               end else if (out_ready_i) begin
                  out_valid_q  <= 1'b0;
                  frame_done_q <= 1'b0;
                  if (!last_beat) idx_q <= idx_q + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy_o       = (state_q != S_IDLE);
   assign out_valid_o  = out_valid_q;
   assign out_line_o   = out_line_q;
   assign x0_o         = x0_q;
   assign y0_o         = y0_q;
   assign z0_o         = z0_q;
   assign x1_o         = x1_q;
   assign y1_o         = y1_q;
   assign z1_o         = z1_q;
   assign frame_done_o = frame_done_q;
   assign bad_line_o   = bad_line_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_cube_line_rotator.sv
// ----------------------------------------------------------------------------
// tb_cube_line_rotator
//
// Bench for cube_line_rotator. The default-parameter instance is checked
// against an integer model of the cube tables and rotation formulas. A
// narrow instance (COORD_W=9, X_OFF=250) shares the inputs and covers
// output saturation.
// ----------------------------------------------------------------------------
module tb_cube_line_rotator;

   localparam int CW   = 13;
   localparam int FRAC = 6;
   localparam int HALF = 10;
   localparam int XO   = 320;
   localparam int YO   = 240;
   localparam int ZO   = 0;
   localparam int CW2  = 9;
   localparam int XO2  = 250;
   localparam int BW   = 4 + 1 + 6 * CW;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic              start_i, sweep_i, out_ready_i;
   logic [3:0]        line_num_i;
   logic signed [7:0] cos_x_i, sin_x_i, cos_y_i, sin_y_i, cos_z_i, sin_z_i;

   logic                 busy_o, out_valid_o, frame_done_o, bad_line_o;
   logic [3:0]           out_line_o;
   logic [2:0]           state_o;
   logic signed [CW-1:0] x0_o, y0_o, z0_o, x1_o, y1_o, z1_o;

   logic                  busy_b, out_valid_b, frame_done_b, bad_line_b;
   logic [3:0]            out_line_b;
   logic [2:0]            state_b;
   logic signed [CW2-1:0] x0_b, y0_b, z0_b, x1_b, y1_b, z1_b;

   cube_line_rotator dut (
      .clk(clk), .reset(reset), .start_i(start_i), .sweep_i(sweep_i),
      .line_num_i(line_num_i),
      .cos_x_i(cos_x_i), .sin_x_i(sin_x_i), .cos_y_i(cos_y_i),
      .sin_y_i(sin_y_i), .cos_z_i(cos_z_i), .sin_z_i(sin_z_i),
      .out_ready_i(out_ready_i), .busy_o(busy_o), .out_valid_o(out_valid_o),
      .out_line_o(out_line_o),
      .x0_o(x0_o), .y0_o(y0_o), .z0_o(z0_o), .x1_o(x1_o), .y1_o(y1_o), .z1_o(z1_o),
      .frame_done_o(frame_done_o), .bad_line_o(bad_line_o), .state_o(state_o)
   );

   cube_line_rotator #(.COORD_W(CW2), .X_OFF(XO2)) dut_narrow (
      .clk(clk), .reset(reset), .start_i(start_i), .sweep_i(sweep_i),
      .line_num_i(line_num_i),
      .cos_x_i(cos_x_i), .sin_x_i(sin_x_i), .cos_y_i(cos_y_i),
      .sin_y_i(sin_y_i), .cos_z_i(cos_z_i), .sin_z_i(sin_z_i),
      .out_ready_i(out_ready_i), .busy_o(busy_b), .out_valid_o(out_valid_b),
      .out_line_o(out_line_b),
      .x0_o(x0_b), .y0_o(y0_b), .z0_o(z0_b), .x1_o(x1_b), .y1_o(y1_b), .z1_o(z1_b),
      .frame_done_o(frame_done_b), .bad_line_o(bad_line_b), .state_o(state_b)
   );

   // ---------------- checking ----------------
   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int vx [8] = '{1, 1, -1, -1, 1, 1, -1, -1};
   int vy [8] = '{1, -1, -1, 1, 1, -1, -1, 1};
   int vz [8] = '{-1, -1, -1, -1, 1, 1, 1, 1};
   int ea [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3};
   int eb [12] = '{1, 2, 3, 0, 5, 6, 7, 4, 4, 5, 6, 7};
   int cur_c [6];   // coefficients currently driven: cx sx cy sy cz sz
   int lat_c [6];   // coefficients the frame in flight was started with

   function automatic int rnd(input int s);
      return (s + (1 << (FRAC - 1))) >>> FRAC;
   endfunction

   function automatic int sat(input int v, input int cw);
      int mx;
      mx = (1 << (cw - 1)) - 1;
      if (v > mx) return mx;
      if (v < -mx - 1) return -mx - 1;
      return v;
   endfunction

   // Rotated vertex before offsets.
   function automatic void model_point(input int vi, output int ox, output int oy, output int oz);
      int x, y, z, y1, z1, x2, z2;
      x  = vx[vi] * HALF;
      y  = vy[vi] * HALF;
      z  = vz[vi] * HALF;
      y1 = rnd(y * lat_c[0] - z * lat_c[1]);
      z1 = rnd(y * lat_c[1] + z * lat_c[0]);
      x2 = rnd(x * lat_c[2] + z1 * lat_c[3]);
      z2 = rnd(-x * lat_c[3] + z1 * lat_c[2]);
      ox = rnd(x2 * lat_c[4] - y1 * lat_c[5]);
      oy = rnd(x2 * lat_c[5] + y1 * lat_c[4]);
      oz = z2;
   endfunction

   function automatic logic [BW-1:0] model_beat(input int ln, input bit fd);
      int ax, ay, az, bx, by, bz;
      model_point(ea[ln], ax, ay, az);
      model_point(eb[ln], bx, by, bz);
      return {4'(ln), fd,
              CW'(sat(ax + XO, CW)), CW'(sat(ay + YO, CW)), CW'(sat(az + ZO, CW)),
              CW'(sat(bx + XO, CW)), CW'(sat(by + YO, CW)), CW'(sat(bz + ZO, CW))};
   endfunction

   // Field k of a packed beat: 5=x0 4=y0 3=z0 2=x1 1=y1 0=z1.
   function automatic int fld(input logic [BW-1:0] e, input int k);
      logic signed [CW-1:0] v;
      v = e[k*CW +: CW];
      return int'(v);
   endfunction

   // ---------------- scoreboard ----------------
   logic [BW-1:0] exp_q[$];
   logic [BW-1:0] mon_e;
   int            beats = 0;

   always @(negedge clk) begin
      if (!reset && out_valid_o && out_ready_i) begin
         if (exp_q.size() == 0) begin
            check("unexpected_beat", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            beats++;
            check("out_line", int'(out_line_o), int'(mon_e[BW-1 -: 4]));
            check("frame_done", int'(frame_done_o), int'(mon_e[6*CW]));
            check("x0", int'(x0_o), fld(mon_e, 5));
            check("y0", int'(y0_o), fld(mon_e, 4));
            check("z0", int'(z0_o), fld(mon_e, 3));
            check("x1", int'(x1_o), fld(mon_e, 2));
            check("y1", int'(y1_o), fld(mon_e, 1));
            check("z1", int'(z1_o), fld(mon_e, 0));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_coefs(input int cx, input int sx, input int cy,
                            input int sy, input int cz, input int sz);
      cur_c = '{cx, sx, cy, sy, cz, sz};
      cos_x_i = 8'(cx); sin_x_i = 8'(sx);
      cos_y_i = 8'(cy); sin_y_i = 8'(sy);
      cos_z_i = 8'(cz); sin_z_i = 8'(sz);
   endtask

   task automatic rand_coefs();
      set_coefs(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128);
   endtask

   // Issue a start from idle; returns just after the sampling edge.
   task automatic launch(input bit sw, input int ln);
      if (sw || ln <= 11) begin
         lat_c = cur_c;
         if (sw) for (int l = 0; l < 12; l++) exp_q.push_back(model_beat(l, l == 11));
         else    exp_q.push_back(model_beat(ln, 1'b0));
      end
      start_i    = 1'b1;
      sweep_i    = sw;
      line_num_i = 4'(ln);
      tick();
      start_i = 1'b0;
   endtask

   // Run until every expected beat is taken; the engine must be idle on the
   // cycle right after the last transfer.
   task automatic drain(input bit rand_ready, input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         out_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         tick();
         n++;
         if (exp_q.size() == 0) check("busy_after_last", int'(busy_o), 0);
      end
      check("drain_timeout", int'(n >= budget), 0);
      exp_q.delete();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, int'(busy_o), 0);
      check({tag, "_valid"}, int'(out_valid_o), 0);
      check({tag, "_line"}, int'(out_line_o), 0);
      check({tag, "_x0"}, int'(x0_o), 0);
      check({tag, "_y1"}, int'(y1_o), 0);
      check({tag, "_z1"}, int'(z1_o), 0);
      check({tag, "_fd"}, int'(frame_done_o), 0);
      check({tag, "_bad"}, int'(bad_line_o), 0);
      check({tag, "_state"}, int'(state_o), 0);
      check({tag, "_nx0"}, int'(x0_b), 0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int b0, hold;
      logic [BW-1:0] e4;
      reset = 1'b1;
      start_i = 1'b0; sweep_i = 1'b0; line_num_i = '0; out_ready_i = 1'b0;
      set_coefs(0, 0, 0, 0, 0, 0);
      tick(); tick();
      check_all_zero("reset");
      reset = 1'b0;
      tick();

      // identity, single line 0, latency and narrow-width saturation
      set_coefs(64, 0, 64, 0, 64, 0);
      out_ready_i = 1'b1;
      launch(1'b0, 0);
      for (int k = 1; k <= 5; k++) begin
         tick();
         if (k < 5) check("lat_low", int'(out_valid_o), 0);
      end
      check("lat_high", int'(out_valid_o), 1);
      check("id_x0", int'(x0_o), 330);
      check("id_y0", int'(y0_o), 250);
      check("id_z0", int'(z0_o), -10);
      check("id_x1", int'(x1_o), 330);
      check("id_y1", int'(y1_o), 230);
      check("id_z1", int'(z1_o), -10);
      check("narrow_valid", int'(out_valid_b), 1);
      check("narrow_x0_sat", int'(x0_b), sat(10 + XO2, CW2));
      check("narrow_y0", int'(y0_b), 250);
      drain(1'b0, 50);

      // Z rotation by 90 degrees
      set_coefs(64, 0, 64, 0, 0, 64);
      launch(1'b0, 0);
      for (int k = 1; k <= 5; k++) tick();
      check("z90_x0", int'(x0_o), 310);
      check("z90_y0", int'(y0_o), 250);
      check("z90_z0", int'(z0_o), -10);
      check("z90_x1", int'(x1_o), 330);
      check("z90_y1", int'(y1_o), 250);
      check("z90_z1", int'(z1_o), -10);
      drain(1'b0, 50);

      // identity sweep with the consumer always ready
      set_coefs(64, 0, 64, 0, 64, 0);
      b0 = beats;
      launch(1'b1, 0);
      drain(1'b0, 200);
      check("sweep_beats", beats - b0, 12);

      // backpressure on line 4 and a coefficient change mid-frame
      rand_coefs();
      launch(1'b1, 0);
      e4 = model_beat(4, 1'b0);
      cos_x_i = cos_x_i + 8'sd37;
      hold = 0;
      b0 = beats;
      for (int n = 0; n < 300 && exp_q.size() != 0; n++) begin
         if (out_valid_o && out_line_o == 4'd4 && hold < 3) begin
            out_ready_i = 1'b0;
            check("bp_valid", int'(out_valid_o), 1);
            check("bp_x0", int'(x0_o), fld(e4, 5));
            check("bp_z1", int'(z1_o), fld(e4, 0));
            hold++;
         end else begin
            out_ready_i = 1'b1;
         end
         tick();
      end
      check("bp_hold_cycles", hold, 3);
      check("bp_beats", beats - b0, 12);
      drain(1'b0, 50);

      // rejected line index, then start while busy
      start_i = 1'b1; sweep_i = 1'b0; line_num_i = 4'd13;
      tick();
      start_i = 1'b0;
      check("bad_pulse", int'(bad_line_o), 1);
      check("bad_busy", int'(busy_o), 0);
      check("bad_valid", int'(out_valid_o), 0);
      tick();
      check("bad_once", int'(bad_line_o), 0);
      check("bad_busy2", int'(busy_o), 0);
      set_coefs(64, 0, 64, 0, 64, 0);
      b0 = beats;
      launch(1'b0, 5);
      start_i = 1'b1; sweep_i = 1'b1; line_num_i = 4'd2;
      tick(); tick();
      start_i = 1'b0;
      drain(1'b0, 50);
      for (int k = 0; k < 8; k++) tick();
      check("busy_start_ignored", beats - b0, 1);
      check("busy_start_idle", int'(busy_o), 0);

      // reset during ROTY, then during OUT
      launch(1'b1, 0);
      tick(); tick();
      check("at_roty_busy", int'(busy_o), 1);
      reset = 1'b1;
      tick();
      check_all_zero("rst_roty");
      reset = 1'b0;
      exp_q.delete();
      tick();
      out_ready_i = 1'b0;
      launch(1'b0, 3);
      for (int k = 1; k <= 6; k++) tick();
      check("out_before_rst", int'(out_valid_o), 1);
      reset = 1'b1;
      tick();
      check_all_zero("rst_out");
      reset = 1'b0;
      exp_q.delete();
      tick();

      // randomized frames against the model
      for (int f = 0; f < 40; f++) begin
         bit sw;
         int ln;
         rand_coefs();
         sw = ($urandom_range(0, 3) == 0);
         ln = int'($urandom_range(0, 15));
         launch(sw, ln);
         check("rand_bad_line", int'(bad_line_o), int'(!sw && ln > 11));
         drain(1'b1, 600);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
